// File: rtl/rr_mux_stream.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_stream
// Brief    : Registered M-to-1 valid/ready stream mux, round-robin or fixed
//            priority arbitration, single output register stage.
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_stream #(
    parameter int N  = 32,
    parameter int M  = 4,
    parameter int RR = 1,
    parameter int SW = $clog2(M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M*N-1:0]   in_data,
    input  logic [M-1:0]     in_valid,
    output logic [M-1:0]     in_ready,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SW-1:0]    out_sel
);

    logic [SW-1:0] r_ptr;
    logic [SW-1:0] r_out_sel;
    logic [N-1:0]  r_out_data;
    logic          r_out_valid;

    logic          w_load;
    logic          w_gnt_found;
    logic          w_in_hs;
    logic [SW-1:0] w_gnt_idx;
    logic [SW-1:0] w_scan_idx;
    logic [SW-1:0] w_ptr_nxt;
    logic [N-1:0]  w_ch [M];

    for (genvar c = 0; c < M; c++) begin : g_unpack
        assign w_ch[c] = in_data[c*N +: N];
    end

    assign w_load = ~r_out_valid | out_ready;

    // First valid channel starting at r_ptr (RR) or at channel 0 (fixed priority).
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan_idx  = '0;
        for (int i = 0; i < M; i++) begin
            w_scan_idx = (RR != 0) ? SW'((int'(r_ptr) + i) % M) : SW'(i);
            if (!w_gnt_found && in_valid[w_scan_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan_idx;
            end
        end
    end

    assign w_in_hs   = w_load & w_gnt_found;
    assign w_ptr_nxt = (w_gnt_idx == SW'(M - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Gated by rst so producers never see ready while the block is held in reset.
    assign in_ready = (w_in_hs && !rst) ? (M'(1) << w_gnt_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_in_hs) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_ch[w_gnt_idx];
            r_out_sel   <= w_gnt_idx;
            if (RR != 0) begin
                r_ptr <= w_ptr_nxt;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_stream
// Brief    : Directed vector-table bench for rr_mux_stream (RR M=4, FP M=4, RR M=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_stream;

    typedef struct {
        logic [3:0]   v;
        logic [127:0] d;
        logic         ordy;
        logic [3:0]   e_rdy;
        logic         e_ov;
        logic [31:0]  e_od;
        logic [1:0]   e_sel;
    } vec_t;

    logic clk;
    logic rst;

    logic [127:0] m_d;
    logic [3:0]   m_v, m_rdy;
    logic [31:0]  m_od;
    logic         m_ov, m_ordy;
    logic [1:0]   m_sel;

    logic [127:0] f_d;
    logic [3:0]   f_v, f_rdy;
    logic [31:0]  f_od;
    logic         f_ov, f_ordy;
    logic [1:0]   f_sel;

    logic [23:0]  t_d;
    logic [2:0]   t_v, t_rdy;
    logic [7:0]   t_od;
    logic         t_ov, t_ordy;
    logic [1:0]   t_sel;

    int n_checks;
    int n_errors;

    localparam logic [127:0] D = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    localparam logic [127:0] DB = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};

    rr_mux_stream #(.N(32), .M(4), .RR(1)) dut (
        .clk(clk), .rst(rst), .in_data(m_d), .in_valid(m_v), .in_ready(m_rdy),
        .out_data(m_od), .out_valid(m_ov), .out_ready(m_ordy), .out_sel(m_sel)
    );

    rr_mux_stream #(.N(32), .M(4), .RR(0)) dut_fp (
        .clk(clk), .rst(rst), .in_data(f_d), .in_valid(f_v), .in_ready(f_rdy),
        .out_data(f_od), .out_valid(f_ov), .out_ready(f_ordy), .out_sel(f_sel)
    );

    rr_mux_stream #(.N(8), .M(3), .RR(1)) dut3 (
        .clk(clk), .rst(rst), .in_data(t_d), .in_valid(t_v), .in_ready(t_rdy),
        .out_data(t_od), .out_valid(t_ov), .out_ready(t_ordy), .out_sel(t_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t t, input int k);
        m_v    = t.v;
        m_d    = t.d;
        m_ordy = t.ordy;
        #1;
        chk($sformatf("vec%0d in_ready", k), 128'(m_rdy), 128'(t.e_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d out_valid", k), 128'(m_ov), 128'(t.e_ov));
        chk($sformatf("vec%0d out_data", k), 128'(m_od), 128'(t.e_od));
        chk($sformatf("vec%0d out_sel", k), 128'(m_sel), 128'(t.e_sel));
    endtask

    vec_t tbl [15];

    initial begin
        n_checks = 0;
        n_errors = 0;
        //            v        d   ordy  e_rdy    ov    od            sel
        tbl[0]  = '{4'b0000, D,  1'b1, 4'b0000, 1'b0, 32'h00000000, 2'd0};
        tbl[1]  = '{4'b0100, DB, 1'b1, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
        tbl[2]  = '{4'b1111, D,  1'b1, 4'b1000, 1'b1, 32'h33333333, 2'd3};
        tbl[3]  = '{4'b1111, D,  1'b1, 4'b0001, 1'b1, 32'h00000000, 2'd0};
        tbl[4]  = '{4'b1111, D,  1'b1, 4'b0010, 1'b1, 32'h11111111, 2'd1};
        tbl[5]  = '{4'b1111, D,  1'b1, 4'b0100, 1'b1, 32'h22222222, 2'd2};
        tbl[6]  = '{4'b1111, D,  1'b0, 4'b0000, 1'b1, 32'h22222222, 2'd2};
        tbl[7]  = '{4'b1111, D,  1'b0, 4'b0000, 1'b1, 32'h22222222, 2'd2};
        tbl[8]  = '{4'b1111, D,  1'b0, 4'b0000, 1'b1, 32'h22222222, 2'd2};
        tbl[9]  = '{4'b1111, D,  1'b1, 4'b1000, 1'b1, 32'h33333333, 2'd3};
        tbl[10] = '{4'b0000, D,  1'b1, 4'b0000, 1'b0, 32'h33333333, 2'd3};
        tbl[11] = '{4'b0000, D,  1'b0, 4'b0000, 1'b0, 32'h33333333, 2'd3};
        tbl[12] = '{4'b0010, D,  1'b0, 4'b0010, 1'b1, 32'h11111111, 2'd1};
        tbl[13] = '{4'b1001, D,  1'b0, 4'b0000, 1'b1, 32'h11111111, 2'd1};
        tbl[14] = '{4'b1001, D,  1'b1, 4'b1000, 1'b1, 32'h33333333, 2'd3};

        m_v = '0; m_d = D; m_ordy = 1'b0;
        f_v = '0; f_d = D; f_ordy = 1'b0;
        t_v = '0; t_d = {8'hC2, 8'hC1, 8'hC0}; t_ordy = 1'b0;

        // Power-on reset; ready must stay low despite valid inputs
        rst = 1'b1;
        m_v = 4'b1111; m_ordy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("por out_valid", 128'(m_ov), 128'(0));
        chk("por out_data", 128'(m_od), 128'(0));
        chk("por out_sel", 128'(m_sel), 128'(0));
        chk("por in_ready", 128'(m_rdy), 128'(0));
        m_v = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 15; k++) step(tbl[k], k);

        // Asynchronous reset mid-stream with a word held (sel=3, data 33333333)
        m_v = 4'b1111; m_ordy = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("rst out_valid", 128'(m_ov), 128'(0));
        chk("rst out_data", 128'(m_od), 128'(0));
        chk("rst out_sel", 128'(m_sel), 128'(0));
        chk("rst in_ready", 128'(m_rdy), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr%0d in_ready", i), 128'(m_rdy), 128'(4'b0001 << (i % 4)));
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d out_sel", i), 128'(m_sel), 128'(i % 4));
            chk($sformatf("rr%0d out_valid", i), 128'(m_ov), 128'(1));
            chk($sformatf("rr%0d out_data", i), 128'(m_od), 128'(D[(i % 4)*32 +: 32]));
        end
        m_v = '0;

        // Fixed priority: channel 1 always beats channel 3
        f_v = 4'b1010; f_ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("fp%0d in_ready", i), 128'(f_rdy), 128'(4'b0010));
            @(posedge clk);
            #1;
            chk($sformatf("fp%0d out_sel", i), 128'(f_sel), 128'(1));
            chk($sformatf("fp%0d out_data", i), 128'(f_od), 128'(32'h11111111));
        end
        f_v = 4'b1000;
        #1;
        chk("fp drop in_ready", 128'(f_rdy), 128'(4'b1000));
        @(posedge clk);
        #1;
        chk("fp drop out_sel", 128'(f_sel), 128'(3));
        f_v = '0;

        // M=3 pointer wrap: grant 2, then 0,1,2,0 with all valid
        t_v = 3'b100; t_ordy = 1'b1;
        #1;
        chk("m3 first in_ready", 128'(t_rdy), 128'(3'b100));
        @(posedge clk);
        #1;
        chk("m3 first out_sel", 128'(t_sel), 128'(2));
        chk("m3 first out_data", 128'(t_od), 128'(8'hC2));
        t_v = 3'b111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("m3 wrap%0d in_ready", i), 128'(t_rdy), 128'(3'b001 << (i % 3)));
            @(posedge clk);
            #1;
            chk($sformatf("m3 wrap%0d out_sel", i), 128'(t_sel), 128'(i % 3));
            chk($sformatf("m3 wrap%0d out_data", i), 128'(t_od), 128'(8'hC0 + (i % 3)));
        end
        t_v = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
